// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared defaults, grant encoding and address decode for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int DEPTH_DEF  = 2;
    localparam int PEND_W     = 32;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    // One-hot decode of a register address; addresses beyond the mask width decode to nothing.
    function automatic logic [PEND_W-1:0] addr_onehot(input logic [31:0] addr);
        logic [PEND_W-1:0] hot;
        hot = '0;
        if (addr < 32'(PEND_W)) hot = PEND_W'(1) << addr;
        return hot;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Requester write ports plus register-file write port of the write-back arbiter.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    // Handshake: a requester entry transfers at a rising edge where valid and ready are both 1;
    // ready depends only on registered queue occupancy, never on valid in the same cycle.
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_dat;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_dat;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_dat;
    logic              regwrite;
    logic [PEND_W-1:0] pend_mask;

    modport master (
        output a_valid, a_addr, a_dat, b_valid, b_addr, b_dat,
        input  a_ready, b_ready, write_addr, write_dat, regwrite, pend_mask
    );

    modport slave (
        input  a_valid, a_addr, a_dat, b_valid, b_addr, b_dat,
        output a_ready, b_ready, write_addr, write_dat, regwrite, pend_mask
    );

endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// Small shift-register queue holding pending register writes, with per-entry visibility.
module wb_fifo2 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_dat,
    output logic [CNT_W-1:0]  count,
    output logic [DEPTH-1:0]  ent_valid,
    output logic [ADDR_W-1:0] ent_addr [DEPTH]
);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] dat_q  [DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  wr_idx;

    // Entry 0 is always the head; a simultaneous pop shifts first so the push lands one slot lower.
    assign wr_idx = pop ? count_q - CNT_W'(1) : count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                dat_q[i]  <= '0;
            end
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    addr_q[i] <= addr_q[i+1];
                    dat_q[i]  <= dat_q[i+1];
                end
            end
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (wr_idx == CNT_W'(i)) begin
                        addr_q[i] <= push_addr;
                        dat_q[i]  <= push_dat;
                    end
                end
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_addr = addr_q[0];
    assign head_dat  = dat_q[0];
    assign count     = count_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i] = CNT_W'(i) < count_q;
            ent_addr[i]  = addr_q[i];
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester write-back arbiter: queues writes per requester and issues one per cycle, round-robin.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              a_push, a_pop, a_rdy;
    logic              b_push, b_pop, b_rdy;
    logic [ADDR_W-1:0] a_head_addr, b_head_addr;
    logic [DATA_W-1:0] a_head_dat, b_head_dat;
    logic [CNT_W-1:0]  a_count, b_count;
    logic [DEPTH-1:0]  a_ent_valid, b_ent_valid;
    logic [ADDR_W-1:0] a_ent_addr [DEPTH];
    logic [ADDR_W-1:0] b_ent_addr [DEPTH];
    logic              grant_a, grant_b, issue;
    logic              last_grant;
    logic [ADDR_W-1:0] write_addr_q;
    logic [DATA_W-1:0] write_dat_q;
    logic              regwrite_q;
    logic [PEND_W-1:0] pend;

    assign a_rdy  = a_count < CNT_W'(DEPTH);
    assign b_rdy  = b_count < CNT_W'(DEPTH);
    assign a_push = bus.a_valid & a_rdy;
    assign b_push = bus.b_valid & b_rdy;

    // A wins when B is empty or when B was the last one served; B takes whatever A does not.
    assign grant_a = (a_count != '0) && ((b_count == '0) || (last_grant == GRANT_B));
    assign grant_b = (b_count != '0) && !grant_a;
    assign issue   = grant_a | grant_b;
    assign a_pop   = grant_a;
    assign b_pop   = grant_b;

    wb_fifo2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push      (a_push),
        .push_addr (bus.a_addr),
        .push_dat  (bus.a_dat),
        .pop       (a_pop),
        .head_addr (a_head_addr),
        .head_dat  (a_head_dat),
        .count     (a_count),
        .ent_valid (a_ent_valid),
        .ent_addr  (a_ent_addr)
    );

    wb_fifo2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push      (b_push),
        .push_addr (bus.b_addr),
        .push_dat  (bus.b_dat),
        .pop       (b_pop),
        .head_addr (b_head_addr),
        .head_dat  (b_head_dat),
        .count     (b_count),
        .ent_valid (b_ent_valid),
        .ent_addr  (b_ent_addr)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            write_addr_q <= '0;
            write_dat_q  <= '0;
            regwrite_q   <= 1'b0;
            last_grant   <= GRANT_B;
        end else begin
            regwrite_q <= issue;
            if (issue) begin
                write_addr_q <= grant_a ? a_head_addr : b_head_addr;
                write_dat_q  <= grant_a ? a_head_dat  : b_head_dat;
                last_grant   <= grant_a ? GRANT_A : GRANT_B;
            end
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a_ent_valid[i]) pend = pend | addr_onehot(32'(a_ent_addr[i]));
            if (b_ent_valid[i]) pend = pend | addr_onehot(32'(b_ent_addr[i]));
        end
    end

    assign bus.a_ready    = a_rdy;
    assign bus.b_ready    = b_rdy;
    assign bus.write_addr = write_addr_q;
    assign bus.write_dat  = write_dat_q;
    assign bus.regwrite   = regwrite_q;
    assign bus.pend_mask  = pend;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes queued at stimulus, checked by a write monitor.
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int W      = ADDR_W + DATA_W;
    localparam int BURST  = 6;

    logic clk;
    logic rst;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] exp_q [$];
    logic [W-1:0] mon_exp;
    int n_cmp = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] dat);
        exp_q.push_back({addr, dat});
    endtask

    // Present one entry on a requester and wait until it is accepted; returns edges consumed.
    task automatic send(input bit side, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] dat, output int edges);
        bit rdy;
        bit done;
        edges = 0;
        done  = 1'b0;
        if (side == 1'b0) begin
            bus.a_valid = 1'b1; bus.a_addr = addr; bus.a_dat = dat;
        end else begin
            bus.b_valid = 1'b1; bus.b_addr = addr; bus.b_dat = dat;
        end
        while (!done) begin
            rdy = (side == 1'b0) ? bus.a_ready : bus.b_ready;
            tick();
            edges++;
            if (rdy) done = 1'b1;
            else if (edges >= 50) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout side=%0d: got no accept in %0d edges, required accept", side, edges);
                done = 1'b1;
            end
        end
    endtask

    // scoreboard monitor: every register-file write must match the oldest expected one
    always @(negedge clk) begin
        if (bus.regwrite === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL write_unexpected: got addr=%0d dat=0x%0h, required no write",
                         bus.write_addr, bus.write_dat);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus.write_addr, bus.write_dat} !== mon_exp) begin
                    n_err++;
                    $display("FAIL write_order: got addr=%0d dat=0x%0h, required addr=%0d dat=0x%0h",
                             bus.write_addr, bus.write_dat,
                             mon_exp[W-1:DATA_W], mon_exp[DATA_W-1:0]);
                end
            end
        end
    end

    initial begin
        int edges;
        int total;
        int wr_seen;
        int a_lo;
        int b_lo;

        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_dat = '0;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_dat = '0;
        rst = 1'b0;
        tick();
        tick();
        check("rst_a_ready",    64'(bus.a_ready),    64'd1);
        check("rst_b_ready",    64'(bus.b_ready),    64'd1);
        check("rst_regwrite",   64'(bus.regwrite),   64'd0);
        check("rst_write_addr", 64'(bus.write_addr), 64'd0);
        check("rst_write_dat",  64'(bus.write_dat),  64'd0);
        check("rst_pend_mask",  64'(bus.pend_mask),  64'd0);
        rst = 1'b1;

        // single write from A, latency and pend window
        bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_dat = 32'h0000_00AA;
        expect_write(5'd3, 32'h0000_00AA);
        tick();
        bus.a_valid = 1'b0;
        check("single_pend_set",    64'(bus.pend_mask), 64'h8);
        check("single_no_early_wr", 64'(bus.regwrite),  64'd0);
        tick();
        check("single_pend_clr",   64'(bus.pend_mask),  64'd0);
        check("single_regwrite",   64'(bus.regwrite),   64'd1);
        check("single_write_addr", 64'(bus.write_addr), 64'd3);
        check("single_write_dat",  64'(bus.write_dat),  64'hAA);
        tick();
        check("single_wr_drop",   64'(bus.regwrite),   64'd0);
        check("single_addr_hold", 64'(bus.write_addr), 64'd3);

        // simultaneous pairs after reset: A wins the first tie, then alternation
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int p = 0; p < 2; p++) begin
            bus.a_valid = 1'b1; bus.a_addr = 5'd1; bus.a_dat = (p == 0) ? 32'h11 : 32'h33;
            bus.b_valid = 1'b1; bus.b_addr = 5'd2; bus.b_dat = (p == 0) ? 32'h22 : 32'h44;
            expect_write(5'd1, (p == 0) ? 32'h11 : 32'h33);
            expect_write(5'd2, (p == 0) ? 32'h22 : 32'h44);
            tick();
            bus.a_valid = 1'b0; bus.b_valid = 1'b0;
            check("pair_pend_both", 64'(bus.pend_mask), 64'h6);
            tick();
            check("pair_pend_b",    64'(bus.pend_mask), 64'h4);
            tick();
            check("pair_pend_none", 64'(bus.pend_mask), 64'h0);
        end

        // B streams four writes while A is idle
        total = 0;
        for (int i = 4; i < 8; i++) begin
            expect_write(5'(i), 32'h0000_00B0 + 32'(i));
            send(1'b1, 5'(i), 32'h0000_00B0 + 32'(i), edges);
            total += edges;
        end
        bus.b_valid = 1'b0;
        check("b_stream_edges", 64'(total), 64'd4);
        tick();
        tick();
        check("b_stream_drained", 64'(bus.pend_mask), 64'h0);

        // both requesters saturate: one write per cycle, alternating A/B
        for (int i = 0; i < BURST; i++) begin
            expect_write(5'(16 + i), 32'hA000_0000 + 32'(i));
            expect_write(5'(24 + i), 32'hB000_0000 + 32'(i));
        end
        wr_seen = 0;
        a_lo = 0;
        b_lo = 0;
        fork
            begin
                int e;
                for (int i = 0; i < BURST; i++) send(1'b0, 5'(16 + i), 32'hA000_0000 + 32'(i), e);
                bus.a_valid = 1'b0;
            end
            begin
                int e;
                for (int i = 0; i < BURST; i++) send(1'b1, 5'(24 + i), 32'hB000_0000 + 32'(i), e);
                bus.b_valid = 1'b0;
            end
            begin
                int w;
                w = 0;
                while (!bus.regwrite && w < 20) begin
                    tick();
                    w++;
                end
                for (int i = 0; i < 2 * BURST; i++) begin
                    if (bus.regwrite) wr_seen++;
                    if (!bus.a_ready) a_lo++;
                    if (!bus.b_ready) b_lo++;
                    tick();
                end
            end
        join
        check("burst_throughput",  64'(wr_seen), 64'(2 * BURST));
        check("burst_a_ready_low", 64'(a_lo > 0), 64'd1);
        check("burst_b_ready_low", 64'(b_lo > 0), 64'd1);
        tick();

        // both heads target register 9; B was served last so A goes first
        bus.a_valid = 1'b1; bus.a_addr = 5'd9; bus.a_dat = 32'h1;
        bus.b_valid = 1'b1; bus.b_addr = 5'd9; bus.b_dat = 32'h2;
        expect_write(5'd9, 32'h1);
        expect_write(5'd9, 32'h2);
        tick();
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        check("same_addr_pend_2", 64'(bus.pend_mask), 64'h200);
        tick();
        check("same_addr_pend_1", 64'(bus.pend_mask), 64'h200);
        tick();
        check("same_addr_pend_0", 64'(bus.pend_mask), 64'h0);

        // reset with three entries queued discards them
        bus.a_valid = 1'b1; bus.a_addr = 5'd20; bus.a_dat = 32'hDEAD_0020;
        bus.b_valid = 1'b1; bus.b_addr = 5'd21; bus.b_dat = 32'hDEAD_0021;
        expect_write(5'd20, 32'hDEAD_0020);
        tick();
        bus.a_addr = 5'd22; bus.a_dat = 32'hDEAD_0022;
        bus.b_addr = 5'd23; bus.b_dat = 32'hDEAD_0023;
        tick();
        bus.b_valid = 1'b0;
        bus.a_addr = 5'd24; bus.a_dat = 32'hDEAD_0024;
        check("pre_rst_pend", 64'(bus.pend_mask), 64'h00E0_0000);
        rst = 1'b0;
        tick();
        bus.a_valid = 1'b0;
        check("mid_rst_regwrite",   64'(bus.regwrite),   64'd0);
        check("mid_rst_pend",       64'(bus.pend_mask),  64'd0);
        check("mid_rst_a_ready",    64'(bus.a_ready),    64'd1);
        check("mid_rst_b_ready",    64'(bus.b_ready),    64'd1);
        check("mid_rst_write_addr", 64'(bus.write_addr), 64'd0);
        check("mid_rst_write_dat",  64'(bus.write_dat),  64'd0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("post_rst_pend", 64'(bus.pend_mask), 64'd0);

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
